uart_mmio_periph: RTL and testbench

Memory-mapped UART peripheral for the RISC-V single-cycle core: 8N1 serial TX/RX with parametrised baud divisor, data width and FIFO depth, exposed to the core as four 32-bit registers.
- Replaces the fixed rx_ready / rx_data / tx_data / clean_rx strap signals with a real buffered serial link.
- Sits on the core's data-memory bus beside data RAM; tx/rx go to board pins.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_mmio_periph.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_mmio_periph.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Register offsets, STATUS/CTRL bit positions and FSM state
//               encodings shared by the UART MMIO peripheral.
//               Optional parity support: `define UART_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Register select values, taken from addr[3:2]
   localparam logic [1:0] REG_TX_DATA = 2'd0;
   localparam logic [1:0] REG_RX_DATA = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   // STATUS bit positions; CTRL W1C bits reuse the flag positions 3..6
   localparam int ST_RX_READY     = 0;
   localparam int ST_TX_FULL      = 1;
   localparam int ST_TX_BUSY      = 2;
   localparam int ST_RX_OVF       = 3;
   localparam int ST_TX_OVF       = 4;
   localparam int ST_FRAME_ERR    = 5;
   localparam int ST_PARITY_ERR   = 6;
   localparam int ST_RX_COUNT_LSB = 16;
   localparam int ST_TX_COUNT_LSB = 24;
   localparam int CTRL_RX_FLUSH   = 0;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_STOP   = 3'd3
`ifdef UART_PARITY_EN
      , TX_PARITY = 3'd4
`endif
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_STOP   = 3'd3,
      RX_WAIT   = 3'd4
`ifdef UART_PARITY_EN
      , RX_PARITY = 3'd5
`endif
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. A pop on an empty
//               FIFO is ignored; a push on a full FIFO succeeds only when a
//               pop happens in the same cycle. clear empties it and wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

   // Storage array, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_periph
// Description : Memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags
//               and a level interrupt. Four 32-bit registers on addr[3:2].
//               Optional even parity: `define UART_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio_periph
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 434,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  addr,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   localparam int CW   = $clog2(BAUD_DIV);
   localparam int BW   = $clog2(DATA_BITS);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   // ---------------- register decode ----------------
   logic [1:0] sel;
   logic       tx_wr, ctrl_wr, rx_rd, flush;
   assign sel     = addr[3:2];
   assign tx_wr   = we & (sel == REG_TX_DATA);
   assign ctrl_wr = we & (sel == REG_CTRL);
   assign rx_rd   = re & (sel == REG_RX_DATA);
   assign flush   = ctrl_wr & wdata[CTRL_RX_FLUSH];

   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata};

   // ---------------- FIFOs ----------------
   logic                 tx_pop, tx_full, tx_empty;
   logic [DATA_BITS-1:0] tx_dout;
   logic [CNTW-1:0]      tx_count;
   logic                 rx_push, rx_full, rx_empty;
   logic [DATA_BITS-1:0] rx_dout, rx_shift;
   logic [CNTW-1:0]      rx_count;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .clear(1'b0), .push(tx_wr), .pop(tx_pop),
      .din(wdata[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full),
      .empty(tx_empty), .count(tx_count));

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .clear(flush), .push(rx_push), .pop(rx_rd),
      .din(rx_shift), .dout(rx_dout), .full(rx_full),
      .empty(rx_empty), .count(rx_count));

   // ---------------- TX path ----------------
   tx_state_t            tx_state, tx_next;
   logic [CW-1:0]        tx_cnt;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_tick;
   assign tx_tick = (tx_cnt == BAUD_LAST);
`ifdef UART_PARITY_EN
   logic                 tx_par;
`endif

   // TX state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   // TX next-state, FIFO pop and serial line value
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      tx      = 1'b1;
      case (tx_state)
         TX_IDLE:  if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
         TX_START: begin
            tx = 1'b0;
            if (tx_tick) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx = tx_shift[0];
            if (tx_tick && tx_bit == BIT_LAST)
`ifdef UART_PARITY_EN
               tx_next = TX_PARITY;
`else
               tx_next = TX_STOP;
`endif
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            tx = tx_par;
            if (tx_tick) tx_next = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (tx_tick) begin
               if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
               else                 tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // TX bit timer and shifter; a new byte is loaded as it is popped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         if (tx_state == TX_IDLE || tx_next != tx_state || tx_tick) tx_cnt <= '0;
         else tx_cnt <= tx_cnt + CW'(1);
         if (tx_pop) begin
            tx_shift <= tx_dout;
            tx_bit   <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_dout;
`endif
         end else if (tx_state == TX_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BW'(1);
         end
      end
   end

   // ---------------- RX path ----------------
   rx_state_t     rx_state, rx_next;
   logic [1:0]    rx_sync;
   logic          rx_s, rx_prev, rx_fall, rx_tick;
   logic [CW-1:0] rx_cnt;
   logic [BW-1:0] rx_bit;
   logic          rx_good, frame_set;
   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_prev & ~rx_s;
   assign rx_tick = (rx_cnt == BAUD_LAST);
`ifdef UART_PARITY_EN
   logic          rx_par_bad, parity_set;
`endif

   // Two-flop synchroniser plus delayed copy for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rx};
         rx_prev <= rx_s;
      end
   end

   // RX state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   // RX next-state and frame verdict
   always_comb begin
      rx_next   = rx_state;
      rx_good   = 1'b0;
      frame_set = 1'b0;
`ifdef UART_PARITY_EN
      parity_set = 1'b0;
`endif
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:
            if (rx_tick && rx_bit == BIT_LAST)
`ifdef UART_PARITY_EN
               rx_next = RX_PARITY;
         RX_PARITY: if (rx_tick) rx_next = RX_STOP;
`else
               rx_next = RX_STOP;
`endif
         RX_STOP: begin
            if (rx_tick) begin
               if (!rx_s) begin
                  frame_set = 1'b1;
                  rx_next   = RX_WAIT;
               end else begin
                  rx_next = RX_IDLE;
`ifdef UART_PARITY_EN
                  if (rx_par_bad) parity_set = 1'b1;
                  else            rx_good    = 1'b1;
`else
                  rx_good = 1'b1;
`endif
               end
            end
         end
         RX_WAIT: if (rx_s) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   // RX bit timer, shifter, and one-cycle-delayed push of a good byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_push  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         rx_push <= rx_good;
         if (rx_state == RX_IDLE || rx_state == RX_WAIT || rx_next != rx_state || rx_tick)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + CW'(1);
         if (rx_state == RX_START) rx_bit <= '0;
         else if (rx_state == RX_DATA && rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + BW'(1);
         end
`ifdef UART_PARITY_EN
         if (rx_state == RX_PARITY && rx_tick) rx_par_bad <= rx_s ^ (^rx_shift);
`endif
      end
   end

   // ---------------- sticky flags ----------------
   logic rx_ovf, tx_ovf, frame_err, parity_err;
   logic [31:0] status;

   // Set has priority over the write-1-to-clear in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_ovf    <= 1'b0;
         tx_ovf    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_ovf    <= (rx_push & rx_full & ~rx_rd & ~flush)
                    | (rx_ovf & ~(ctrl_wr & wdata[ST_RX_OVF]));
         tx_ovf    <= (tx_wr & tx_full & ~tx_pop)
                    | (tx_ovf & ~(ctrl_wr & wdata[ST_TX_OVF]));
         frame_err <= frame_set | (frame_err & ~(ctrl_wr & wdata[ST_FRAME_ERR]));
      end
   end

`ifdef UART_PARITY_EN
   // Parity error flag, same set-over-clear rule
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) parity_err <= 1'b0;
      else parity_err <= parity_set | (parity_err & ~(ctrl_wr & wdata[ST_PARITY_ERR]));
   end
`else
   assign parity_err = 1'b0;
`endif

   assign irq = ~rx_empty | rx_ovf | tx_ovf | frame_err | parity_err;

   // STATUS word assembly and combinational read mux
   always_comb begin
      status = '0;
      status[ST_RX_READY]   = ~rx_empty;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_BUSY]    = ~tx_empty | (tx_state != TX_IDLE);
      status[ST_RX_OVF]     = rx_ovf;
      status[ST_TX_OVF]     = tx_ovf;
      status[ST_FRAME_ERR]  = frame_err;
      status[ST_PARITY_ERR] = parity_err;
      status[ST_RX_COUNT_LSB +: 4] = 4'(rx_count);
      status[ST_TX_COUNT_LSB +: 4] = 4'(tx_count);
      rdata = '0;
      case (sel)
         REG_RX_DATA: if (!rx_empty) rdata = 32'(rx_dout);
         REG_STATUS:  rdata = status;
         default:     rdata = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_periph.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio_periph
// Description : Directed self-checking bench for uart_mmio_periph with
//               BAUD_DIV=8, DATA_BITS=8, FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_periph;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  addr  = 4'h0;
   logic        we    = 1'b0;
   logic        re    = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rx    = 1'b1;
   logic        tx;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;
   logic [9:0] frame;

   uart_mmio_periph #(.BAUD_DIV(8), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re),
      .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (8) step();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (8) step();
      end
      rx = stop_bit;
      repeat (8) step();
      rx = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      // Reset state
      #2 reset = 1'b0;
      #1;
      check("reset_tx", tx, 1);
      check("reset_irq", irq, 0);
      rd(4'h0, 32'h0, "reset_rd0");
      rd(4'h4, 32'h0, "reset_rd4");
      rd(4'h8, 32'h0, "reset_rd8");
      rd(4'hC, 32'h0, "reset_rdC");
      step();
      reset = 1'b1;
      step();

      // Single TX frame 0x55
      wr(4'h0, 32'h55);
      check("tx_idle_after_wr", tx, 1);
      rd(4'h8, 32'h0100_0004, "status_after_wr");
      frame = {1'b1, 8'h55, 1'b0};
      for (int k = 1; k <= 80; k++) begin
         step();
         check($sformatf("tx_frame55_c%0d", k), tx, frame[(k-1)/8]);
      end
      step();
      rd(4'h8, 32'h0, "status_tx_done");
      check("tx_idle_done", tx, 1);

      // Five back-to-back writes fit, sixth overflows
      for (int i = 1; i <= 5; i++) wr(4'h0, 32'(i));
      rd(4'h8, 32'h0400_0006, "status_5wr");
      check("irq_5wr", irq, 0);
      wr(4'h0, 32'h6);
      rd(4'h8, 32'h0400_0016, "status_6wr_ovf");
      check("irq_tx_ovf", irq, 1);
      rd(4'h0, 32'h0, "rd_txdata_zero");
      rd(4'hC, 32'h0, "rd_ctrl_zero");
      wr(4'hC, 32'h10);
      rd(4'h8, 32'h0400_0006, "status_ovf_clr");
      check("irq_ovf_clr", irq, 0);
      // Five frames back to back end exactly 400 cycles after the first pop
      repeat (394) step();
      rd(4'h8, 32'h0000_0004, "status_last_stop");
      step();
      rd(4'h8, 32'h0, "status_drained");

      // Good RX frame 0xA3
      send_frame(8'hA3, 1'b1);
      rd(4'h8, 32'h0001_0001, "status_rx1");
      check("irq_rx1", irq, 1);
      rd(4'h4, 32'h0000_00A3, "rxdata_a3");
      re = 1'b1;
      step();
      re = 1'b0;
      rd(4'h8, 32'h0, "status_rx_popped");
      check("irq_rx_popped", irq, 0);
      rd(4'h4, 32'h0, "rxdata_empty");
      re = 1'b1;
      step();
      re = 1'b0;
      rd(4'h8, 32'h0, "status_empty_pop");

      // Framing error, then clear
      send_frame(8'h5A, 1'b0);
      rd(4'h8, 32'h0000_0020, "status_frame_err");
      check("irq_frame_err", irq, 1);
      wr(4'hC, 32'h20);
      rd(4'h8, 32'h0, "status_frame_clr");

      // Short low glitch is rejected
      rx = 1'b0;
      repeat (2) step();
      rx = 1'b1;
      repeat (20) step();
      rd(4'h8, 32'h0, "status_glitch");
      check("irq_glitch", irq, 0);

      // RX overflow with five unread frames, then flush
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      send_frame(8'h55, 1'b1);
      rd(4'h8, 32'h0004_0009, "status_rx_ovf");
      rd(4'h4, 32'h0000_0011, "rxdata_head");
      wr(4'hC, 32'h01);
      rd(4'h8, 32'h0000_0008, "status_flushed");
      wr(4'hC, 32'h08);
      rd(4'h8, 32'h0, "status_rxovf_clr");

      // Reset in the middle of a TX frame
      wr(4'h0, 32'h00);
      repeat (20) step();
      check("tx_low_midframe", tx, 0);
      reset = 1'b0;
      #1;
      check("tx_async_reset", tx, 1);
      step();
      reset = 1'b1;
      step();
      rd(4'h8, 32'h0, "status_after_reset");
      check("tx_after_reset", tx, 1);
      check("irq_after_reset", irq, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
